rom_streamer: RTL and testbench
===============================

ROM_STREAMER -- requirements
Module: rom_streamer

Interface
REQ-001 SHALL have parameter D, default 8: ROM data width in bits.
REQ-002 SHALL have parameter A, default 14: ROM address width in bits.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a burst; sampled only in IDLE.
REQ-006 SHALL have port base, input, A: first ROM address of the burst, sampled with start.
REQ-007 SHALL have port len, input, A+1: beat count, 0..2^A, sampled with start.
REQ-008 SHALL have port rom_a, output, A: address to the synchronous ROM, which has 1-cycle registered read latency.
REQ-009 SHALL have port rom_do, input, D: ROM read data, valid the cycle after the address edge.
REQ-010 SHALL have port m_data, output, D: stream data.
REQ-011 SHALL have port m_valid, output, 1: stream data valid.
REQ-012 SHALL have port m_ready, input, 1: downstream accept; a beat transfers on m_valid && m_ready at a clock edge.
REQ-013 SHALL have port busy, output, 1: burst in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at burst end.

Function
REQ-015 SHALL implement states IDLE, RUN and DRAIN: IDLE->RUN on start with len>0; RUN->DRAIN when the last address is issued; DRAIN->IDLE on the last beat handshake.
REQ-016 SHALL, on start with len=0, stay in IDLE, emit no beats and pulse done in the next cycle.
REQ-017 SHALL ignore start while not in IDLE.
REQ-018 SHALL issue addresses base, base+1, ..., wrapping modulo 2^A past 2^A-1, exactly len addresses, each address issued once.
REQ-019 SHALL buffer returned data in a 2-entry FIFO and issue a read only if occupancy + in-flight - pop < 2, so no data is ever dropped.
REQ-020 SHALL assert m_valid two cycles after the start edge (start at edge E0, address issued at E1, FIFO written at E2) when the FIFO is empty and m_ready is irrelevant.
REQ-021 SHALL sustain one beat per cycle while m_ready is held high.
REQ-022 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-023 SHALL keep busy=1 from the cycle after start until the last beat handshake, then drive busy=0 and done=1 in the following cycle.
REQ-024 SHALL hold rom_a at its last issued value when not issuing.

Reset
REQ-025 SHALL, on reset (including mid-burst), enter IDLE, empty the FIFO, discard in-flight data, and drive m_valid=0, busy=0, done=0, rom_a=0, m_data=0 in the next cycle.
REQ-026 SHALL not pulse done for a burst aborted by reset.

Configuration
REQ-027 SHALL, with ROM_STREAM_CHECKSUM_EN defined, add output port sum (D bits), cleared on start and incremented modulo 2^D by m_data on every handshake, valid when done pulses.
REQ-028 SHALL, without ROM_STREAM_CHECKSUM_EN, have no sum port and no checksum logic.

Structure
REQ-029 SHALL place the state encoding (IDLE/RUN/DRAIN) and the default D/A constants in shared package rom_stream_pkg.
REQ-030 SHALL implement the 2-entry FIFO as sub-module rom_stream_fifo (parameter D; push, pop, full, empty, occupancy).

Verification
REQ-031 SHALL cover: base=0x0010, len=4, m_ready=1 -> m_valid rises 2 cycles after start; beats equal ROM[0x10..0x13] on 4 consecutive cycles; done pulses the cycle after the last beat.
REQ-032 SHALL cover: base=0x3FFE, len=4 -> beats equal ROM[0x3FFE], ROM[0x3FFF], ROM[0x0000], ROM[0x0001].
REQ-033 SHALL cover: len=8 with m_ready toggling 1,0,0,1 repeating -> all 8 beats are delivered in order with none duplicated, and m_data is stable while stalled.
REQ-034 SHALL cover: len=0 -> no m_valid, busy stays 0, done pulses one cycle after start.
REQ-035 SHALL cover: reset asserted after the 3rd beat of len=16 -> m_valid=0 and busy=0 next cycle, no done; a new start with base=0 restarts cleanly.
REQ-036 SHALL cover, with ROM_STREAM_CHECKSUM_EN defined: ROM bytes 0xFF,0x02 and len=2 -> sum=0x01 when done pulses.

Source files
------------

// File: rtl/rom_stream_pkg.sv
// Shared types and default sizes for the ROM burst streamer.
package rom_stream_pkg;

   localparam int D_DEF = 8;    // ROM data width
   localparam int A_DEF = 14;   // ROM address width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/rom_streamer_if.sv
// Bundle of burst control, ROM port and output stream for rom_streamer.
// With ROM_STREAM_CHECKSUM_EN defined the bundle also carries the running checksum.
interface rom_streamer_if
   import rom_stream_pkg::*;
#(
   parameter int D = D_DEF,
   parameter int A = A_DEF
) ();

   logic         start;
   logic [A-1:0] base;
   logic [A:0]   len;
   logic         busy;
   logic         done;
   logic [A-1:0] rom_a;
   logic [D-1:0] rom_do;
   logic [D-1:0] m_data;
   logic         m_valid;
   logic         m_ready;
`ifdef ROM_STREAM_CHECKSUM_EN
   logic [D-1:0] sum;
`endif

   // streamer side
   modport master (
      input  start, base, len, rom_do, m_ready,
      output busy, done, rom_a, m_data, m_valid
`ifdef ROM_STREAM_CHECKSUM_EN
      , output sum
`endif
   );

   // environment side (controller, ROM, stream sink)
   modport slave (
      output start, base, len, rom_do, m_ready,
      input  busy, done, rom_a, m_data, m_valid
`ifdef ROM_STREAM_CHECKSUM_EN
      , input sum
`endif
   );

endinterface

// File: rtl/rom_stream_fifo.sv
// Two-entry FIFO holding ROM read data until the stream sink accepts it.
// The caller never pushes when full or pops when empty.
module rom_stream_fifo #(
   parameter int D = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic [D-1:0] din_i,
   input  logic         pop_i,
   output logic [D-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [1:0]   occupancy_o
);

   logic [D-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   cnt_q;

   // storage, pointers and count; cleared so the head reads zero after reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign dout_o      = mem_q[rd_ptr_q];
   assign full_o      = (cnt_q == 2'd2);
   assign empty_o     = (cnt_q == 2'd0);
   assign occupancy_o = cnt_q;

endmodule

// File: rtl/rom_streamer.sv
// Streams a burst of consecutive ROM words (address wraps modulo 2^A) out
// through a valid/ready port. Reads are throttled so that FIFO occupancy
// plus the one read in flight never exceeds two entries.
// Optional feature: ROM_STREAM_CHECKSUM_EN adds a modulo-2^D sum of all
// delivered beats, cleared on start.
module rom_streamer
   import rom_stream_pkg::*;
#(
   parameter int D = D_DEF,
   parameter int A = A_DEF
) (
   input  logic            clock,
   input  logic            reset,
   rom_streamer_if.master  bus
);

   localparam logic [A-1:0] ONE_A   = 1;
   localparam logic [A:0]   ONE_LEN = 1;

   state_t       state_q;
   logic [A-1:0] addr_q, addr_d;
   logic [A:0]   rem_q, rem_d;
   logic [A-1:0] rom_a_q;
   logic         inflight_q;
   logic         busy_q;
   logic         done_q;

   logic [1:0]   occ;
   logic         empty, full, pop, issue, last_beat;
   logic [D-1:0] head;

   assign pop    = !empty && bus.m_ready;
   // room check: entries held + read in flight - entry leaving now < 2
   assign issue  = (state_q == RUN) &&
                   (({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
   assign addr_d = addr_q + ONE_A;
   assign rem_d  = rem_q - ONE_LEN;
   assign last_beat = (state_q == DRAIN) && pop && !inflight_q && (occ == 2'd1);

   // the ROM samples the address on the edge that ends the issue cycle
   assign bus.rom_a   = issue ? addr_q : rom_a_q;
   assign bus.m_data  = head;
   assign bus.m_valid = !empty;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

   rom_stream_fifo #(.D(D)) u_fifo (
      .clk_i       (clock),
      .rst_i       (reset),
      .push_i      (inflight_q && !full),
      .din_i       (bus.rom_do),
      .pop_i       (pop),
      .dout_o      (head),
      .full_o      (full),
      .empty_o     (empty),
      .occupancy_o (occ)
   );

   // burst control FSM with address generator and registered status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         rom_a_q    <= '0;
         inflight_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= issue;
         if (issue) begin
            rom_a_q <= addr_q;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
         end
         case (state_q)
            IDLE: if (bus.start) begin
               addr_q <= bus.base;
               rem_q  <= bus.len;
               if (bus.len == '0) begin
                  done_q <= 1'b1;
               end else begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end
            end
            RUN: if (issue && (rem_q == ONE_LEN)) state_q <= DRAIN;
            DRAIN: if (last_beat) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef ROM_STREAM_CHECKSUM_EN
   logic [D-1:0] sum_q;

   // running sum of delivered beats, restarted by each accepted start
   always_ff @(posedge clock) begin
      if (reset)                               sum_q <= '0;
      else if ((state_q == IDLE) && bus.start) sum_q <= '0;
      else if (pop)                            sum_q <= sum_q + head;
   end

   assign bus.sum = sum_q;
`endif

endmodule

// File: tb/tb_rom_streamer.sv
// Scoreboard bench for rom_streamer: bursts push expected ROM words into a
// queue, a monitor pops and compares on every stream handshake and checks
// latency, stall stability, done timing and busy.
module tb_rom_streamer;

   localparam int D = 8;
   localparam int A = 14;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   rom_streamer_if #(.D(D), .A(A)) bus ();
   rom_streamer #(.D(D), .A(A)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // synchronous ROM model, one cycle read latency
   logic [D-1:0] rom_mem [0:(1<<A)-1];
   always @(posedge clock) bus.rom_do <= rom_mem[bus.rom_a];

   logic [D-1:0] exp_q [$];
   logic [D-1:0] exp_sum = '0;
   int  burst_id = 0, seen_id = 0, done_id = 0, last_hs_id = 0;
   int  start_cyc = 0, last_hs_cyc = 0, hs_cnt = 0;
   bit  burst_zero = 1'b0, done_ok = 1'b0, consec = 1'b1, stall_hold = 1'b0;
   logic [D-1:0] stall_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: samples mid low phase, after the stimulus has settled
   always @(negedge clock) begin
      #2;
      if (!reset) begin
         if (stall_hold) begin
            chk("stall_valid", {31'b0, bus.m_valid}, 1);
            chk("stall_data", bus.m_data, stall_data);
         end
         if (bus.m_valid && seen_id != burst_id) begin
            chk("first_valid_latency", cyc, start_cyc + 3);
            seen_id = burst_id;
         end
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: got data 0x%0h, expected no beat (cycle %0d)", bus.m_data, cyc);
            end else begin
               chk("beat_data", bus.m_data, exp_q.pop_front());
               if (consec && last_hs_id == burst_id) chk("beat_spacing", cyc, last_hs_cyc + 1);
            end
            last_hs_cyc = cyc;
            last_hs_id  = burst_id;
            hs_cnt++;
         end
         stall_hold = bus.m_valid && !bus.m_ready;
         stall_data = bus.m_data;
         if (bus.done) begin
            chk("done_expected", {31'b0, done_ok && (done_id != burst_id)}, 1);
            chk("done_timing", cyc, burst_zero ? start_cyc + 1 : last_hs_cyc + 1);
            chk("busy_at_done", {31'b0, bus.busy}, 0);
            chk("beats_left_at_done", exp_q.size(), 0);
`ifdef ROM_STREAM_CHECKSUM_EN
            chk("sum_at_done", bus.sum, exp_sum);
`endif
            done_id = burst_id;
         end
      end else begin
         stall_hold = 1'b0;
      end
   end

   task automatic start_burst(input logic [A-1:0] b, input logic [A:0] n);
      logic [A-1:0] ad;
      @(negedge clock);
      exp_sum = '0;
      for (int i = 0; i < int'(n); i++) begin
         ad = b + A'(i);
         exp_q.push_back(rom_mem[ad]);
         exp_sum = exp_sum + rom_mem[ad];
      end
      burst_zero = (n == 0);
      done_ok    = 1'b1;
      start_cyc  = cyc;
      burst_id++;
      bus.start = 1'b1;
      bus.base  = b;
      bus.len   = n;
   endtask

   // mode 0: m_ready held high; mode 1: m_ready cycles 1,0,0,1
   task automatic wait_done(input int mode);
      int k = 0;
      do begin
         @(negedge clock);
         bus.start   = 1'b0;
         bus.m_ready = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
         k++;
         #3;
      end while (done_id != burst_id && k < 300);
      chk("burst_completed", done_id, burst_id);
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         #3;
         chk("idle_valid", {31'b0, bus.m_valid}, 0);
         chk("idle_busy", {31'b0, bus.busy}, 0);
         chk("idle_done", {31'b0, bus.done}, 0);
      end
   endtask

   task automatic reset_state_check();
      chk("rst_valid", {31'b0, bus.m_valid}, 0);
      chk("rst_busy", {31'b0, bus.busy}, 0);
      chk("rst_done", {31'b0, bus.done}, 0);
      chk("rst_rom_a", bus.rom_a, 0);
      chk("rst_m_data", bus.m_data, 0);
   endtask

   initial begin
      int h0, k;
      for (int i = 0; i < (1 << A); i++) rom_mem[i] = 8'(i * 37 + (i >> 8));
      bus.start = 1'b0; bus.base = '0; bus.len = '0; bus.m_ready = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      reset_state_check();
      reset = 1'b0;

      // basic burst, sink always ready
      bus.m_ready = 1'b1;
      start_burst(14'h0010, 15'd4);
      wait_done(0);
      chk("rom_a_hold", bus.rom_a, 14'h0013);
      idle_check(2);

      // wrap past the top of the address space
      start_burst(14'h3FFE, 15'd4);
      wait_done(0);

      // stalling sink: no drops, no duplicates, data held while stalled
      consec = 1'b0;
      start_burst(14'h0123, 15'd8);
      wait_done(1);
      consec = 1'b1;

      // zero-length burst
      start_burst(14'h0500, 15'd0);
      wait_done(0);
      idle_check(3);

      // single beat, then a long wrapping burst at full rate
      start_burst(14'h2222, 15'd1);
      wait_done(0);
      start_burst(14'h3FF0, 15'd20);
      wait_done(0);

      // start while busy is ignored
      start_burst(14'h0040, 15'd6);
      @(negedge clock);
      bus.start = 1'b1; bus.base = 14'h0700; bus.len = 15'd3;
      wait_done(0);
      idle_check(2);

      // reset after the third beat aborts without done
      start_burst(14'h0100, 15'd16);
      h0 = hs_cnt;
      k  = 0;
      do begin
         @(negedge clock);
         bus.start = 1'b0; bus.m_ready = 1'b1;
         k++;
         #3;
      end while (hs_cnt < h0 + 3 && k < 100);
      chk("beats_before_reset", hs_cnt - h0, 3);
      @(negedge clock);
      reset   = 1'b1;
      done_ok = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      #1;
      reset_state_check();
      idle_check(5);
      start_burst(14'h0000, 15'd4);
      wait_done(0);

`ifdef ROM_STREAM_CHECKSUM_EN
      rom_mem[14'h0200] = 8'hFF;
      rom_mem[14'h0201] = 8'h02;
      start_burst(14'h0200, 15'd2);
      wait_done(0);
      chk("checksum_ff_02", bus.sum, 8'h01);
`endif

      idle_check(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
